// File: rtl/alt_vipvfr120_burst_read_cmd_gen_if.sv
// Signal bundle between the burst read command generator, its Avalon-MM master and the word consumer.
// slave = generator side, master = the surrounding logic that drives start/readdata/stall/dout_ready.
interface alt_vipvfr120_burst_read_cmd_gen_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int LEN_WIDTH   = 11,
    parameter int COUNT_WIDTH = 24
);
    logic                   start;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [COUNT_WIDTH-1:0] total_words;
    logic                   busy;
    logic                   done;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   command;
    logic                   is_burst;
    logic                   is_write_not_read;
    logic [LEN_WIDTH-1:0]   burst_length;
    logic                   read;
    logic [DATA_WIDTH-1:0]  readdata;
    logic                   stall;
    logic [DATA_WIDTH-1:0]  dout;
    logic                   dout_valid;
    logic                   dout_ready;

    modport slave (
        input  start, base_addr, total_words, readdata, stall, dout_ready,
        output busy, done, addr, command, is_burst, is_write_not_read,
               burst_length, read, dout, dout_valid
    );

    modport master (
        output start, base_addr, total_words, readdata, stall, dout_ready,
        input  busy, done, addr, command, is_burst, is_write_not_read,
               burst_length, read, dout, dout_valid
    );
endinterface

// File: rtl/alt_vipvfr120_burst_read_cmd_gen.sv
// Splits a (base_addr, total_words) read request into bursts of at most MAX_BURST words and pops the returned
// words into a one-entry output register; first command one cycle after start; stall freezes command and pops, dout_ready=0 blocks pops.
module alt_vipvfr120_burst_read_cmd_gen #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 11,
    parameter int MAX_BURST      = 32,
    parameter int COUNT_WIDTH    = 24,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    alt_vipvfr120_burst_read_cmd_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CMD, DRAIN} state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  cur_addr_q;
    logic [ADDR_WIDTH-1:0]  cur_addr_d;
    logic [COUNT_WIDTH-1:0] cmd_left_q;
    logic [COUNT_WIDTH-1:0] cmd_left_d;
    logic [COUNT_WIDTH-1:0] rd_left_q;
    logic [LEN_WIDTH-1:0]   burst_length_q;
    logic                   command_q;
    logic                   busy_q;
    logic                   done_q;
    logic [DATA_WIDTH-1:0]  dout_q;
    logic                   dout_valid_q;
    logic                   read_w;
    logic                   pop;
    logic                   cmd_acc;

    function automatic logic [LEN_WIDTH-1:0] burst_len(input logic [COUNT_WIDTH-1:0] left);
        if (left > COUNT_WIDTH'(MAX_BURST)) begin
            return LEN_WIDTH'(MAX_BURST);
        end
        return LEN_WIDTH'(left);
    endfunction

    // Pops only when the output register is empty or being emptied this cycle.
    assign read_w  = (state_q != IDLE) && (rd_left_q != '0) && (!dout_valid_q || bus.dout_ready);
    assign pop     = read_w && !bus.stall;
    assign cmd_acc = command_q && !bus.stall;

    assign cur_addr_d = cur_addr_q + ADDR_WIDTH'(burst_length_q) * ADDR_WIDTH'(BYTES_PER_WORD);
    assign cmd_left_d = cmd_left_q - COUNT_WIDTH'(burst_length_q);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= IDLE;
            cur_addr_q     <= '0;
            cmd_left_q     <= '0;
            rd_left_q      <= '0;
            burst_length_q <= '0;
            command_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            dout_q         <= '0;
            dout_valid_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (pop) begin
                dout_q       <= bus.readdata;
                dout_valid_q <= 1'b1;
                rd_left_q    <= rd_left_q - COUNT_WIDTH'(1);
            end else if (bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cur_addr_q <= bus.base_addr;
                        cmd_left_q <= bus.total_words;
                        rd_left_q  <= bus.total_words;
                        busy_q     <= 1'b1;
                        if (bus.total_words == '0) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q        <= CMD;
                            command_q      <= 1'b1;
                            burst_length_q <= burst_len(bus.total_words);
                        end
                    end
                end
                CMD: begin
                    if (cmd_acc) begin
                        cur_addr_q <= cur_addr_d;
                        cmd_left_q <= cmd_left_d;
                        if (cmd_left_d == '0) begin
                            command_q <= 1'b0;
                            state_q   <= DRAIN;
                        end else begin
                            burst_length_q <= burst_len(cmd_left_d);
                        end
                    end
                end
                DRAIN: begin
                    if (rd_left_q == '0 && !dout_valid_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.addr              = cur_addr_q;
    assign bus.command           = command_q;
    assign bus.is_burst          = 1'b1;
    assign bus.is_write_not_read = 1'b0;
    assign bus.burst_length      = burst_length_q;
    assign bus.read              = read_w;
    assign bus.dout              = dout_q;
    assign bus.dout_valid        = dout_valid_q;
endmodule

// File: tb/tb_alt_vipvfr120_burst_read_cmd_gen.sv
// Bench for the burst read command generator: randomized transfers checked against a burst-splitting model.
module tb_alt_vipvfr120_burst_read_cmd_gen;
    localparam int MAXB = 32;
    localparam int BPW  = 4;

    logic clock;
    logic reset;

    alt_vipvfr120_burst_read_cmd_gen_if bus ();

    alt_vipvfr120_burst_read_cmd_gen dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int vectors = 0;
    int fails   = 0;

    logic [42:0] cmd_log[$];
    logic [42:0] exp_cmd[$];
    logic [31:0] dout_log[$];
    int          done_cnt    = 0;
    int          cmd_hi_cnt  = 0;
    int          read_hi_cnt = 0;
    int          pop_cnt     = 0;
    bit          pop_now     = 1'b0;
    int          c0, w0, d0, p0;

    function automatic logic [31:0] word_of(input int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h1357_2468;
    endfunction

    // The emulated master returns word_of(n) for the n-th pop ever made.
    assign bus.readdata = word_of(pop_cnt);

    always @(negedge clock) begin
        if (bus.command && !bus.stall) cmd_log.push_back({bus.addr, bus.burst_length});
        if (bus.dout_valid && bus.dout_ready) dout_log.push_back(bus.dout);
        if (bus.done) done_cnt++;
        if (bus.command) cmd_hi_cnt++;
        if (bus.read) read_hi_cnt++;
        pop_now = bus.read && !bus.stall;
    end

    always @(posedge clock) begin
        if (pop_now) pop_cnt <= pop_cnt + 1;
    end

    // Reference: full MAX_BURST bursts at consecutive addresses, then the remainder.
    function automatic void model_cmds(input logic [31:0] base, input int total);
        int n;
        exp_cmd.delete();
        for (int w = 0; w < total; w += MAXB) begin
            n = (total - w < MAXB) ? (total - w) : MAXB;
            exp_cmd.push_back({32'(base + 32'(w * BPW)), 11'(n)});
        end
    endfunction

    task automatic snap();
        c0 = cmd_log.size();
        w0 = dout_log.size();
        d0 = done_cnt;
        p0 = pop_cnt;
    endtask

    task automatic start_xfer(input logic [31:0] base, input int total);
        bus.start       = 1'b1;
        bus.base_addr   = base;
        bus.total_words = 24'(total);
        @(posedge clock); #1;
        bus.start       = 1'b0;
        bus.base_addr   = $urandom;
        bus.total_words = 24'($urandom);
    endtask

    task automatic drive_until_done(input int stall_pct, input int rdy_pct, input int budget, output bit to);
        to = 1'b1;
        for (int n = 0; n < budget; n++) begin
            bus.stall      = ($urandom_range(99) < stall_pct);
            bus.dout_ready = ($urandom_range(99) < rdy_pct);
            @(posedge clock); #1;
            if (bus.done) begin
                to = 1'b0;
                break;
            end
        end
        bus.stall      = 1'b0;
        bus.dout_ready = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b1;
        bus.base_addr = $urandom;
        bus.total_words = 24'($urandom_range(1, 50));
        repeat (3) @(posedge clock);
        #1;
        vectors++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
        vectors++; if (bus.command !== 1'b0) begin fails++; $display("FAIL reset_command got %b want 0", bus.command); end
        vectors++; if (bus.read !== 1'b0) begin fails++; $display("FAIL reset_read got %b want 0", bus.read); end
        vectors++; if (bus.dout_valid !== 1'b0) begin fails++; $display("FAIL reset_dout_valid got %b want 0", bus.dout_valid); end
        vectors++; if (bus.addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", bus.addr); end
        vectors++; if (bus.burst_length !== 11'h0) begin fails++; $display("FAIL reset_burst_length got %0d want 0", bus.burst_length); end
        vectors++; if (bus.dout !== 32'h0) begin fails++; $display("FAIL reset_dout got %h want 0", bus.dout); end
        vectors++; if (bus.is_burst !== 1'b1) begin fails++; $display("FAIL is_burst got %b want 1", bus.is_burst); end
        vectors++; if (bus.is_write_not_read !== 1'b0) begin fails++; $display("FAIL is_write_not_read got %b want 0", bus.is_write_not_read); end
        bus.start = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_basic_70();
        bit to;
        logic [31:0] base = 32'h1000;
        int total = 70;
        snap();
        start_xfer(base, total);
        drive_until_done(0, 100, 500, to);
        model_cmds(base, total);
        vectors++; if (to) begin fails++; $display("FAIL basic_timeout got no done want done"); end
        vectors++; if (cmd_log.size() - c0 !== exp_cmd.size()) begin fails++; $display("FAIL basic_cmd_count got %0d want %0d", cmd_log.size() - c0, exp_cmd.size()); end
        foreach (exp_cmd[i]) if (c0 + i < cmd_log.size()) begin
            vectors++; if (cmd_log[c0 + i] !== exp_cmd[i]) begin fails++; $display("FAIL basic_cmd%0d got %h want %h", i, cmd_log[c0 + i], exp_cmd[i]); end
        end
        vectors++; if (dout_log.size() - w0 !== total) begin fails++; $display("FAIL basic_words got %0d want %0d", dout_log.size() - w0, total); end
        for (int i = 0; i < total && w0 + i < dout_log.size(); i++) begin
            vectors++; if (dout_log[w0 + i] !== word_of(p0 + i)) begin fails++; $display("FAIL basic_word%0d got %h want %h", i, dout_log[w0 + i], word_of(p0 + i)); end
        end
        vectors++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL basic_done got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_zero();
        int ch0, rh0;
        snap();
        ch0 = cmd_hi_cnt;
        rh0 = read_hi_cnt;
        start_xfer($urandom, 0);
        vectors++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL zero_busy_after_start got %b want 1", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin fails++; $display("FAIL zero_done_early got %b want 0", bus.done); end
        @(posedge clock); #1;
        vectors++; if (bus.done !== 1'b1) begin fails++; $display("FAIL zero_done got %b want 1", bus.done); end
        vectors++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL zero_busy_at_done got %b want 0", bus.busy); end
        @(posedge clock); #1;
        vectors++; if (bus.done !== 1'b0) begin fails++; $display("FAIL zero_done_pulse got %b want 0", bus.done); end
        repeat (2) @(posedge clock);
        #1;
        vectors++; if (cmd_hi_cnt !== ch0) begin fails++; $display("FAIL zero_command_cycles got %0d want %0d", cmd_hi_cnt, ch0); end
        vectors++; if (read_hi_cnt !== rh0) begin fails++; $display("FAIL zero_read_cycles got %0d want %0d", read_hi_cnt, rh0); end
        vectors++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL zero_done_count got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_stall();
        bit to;
        logic [31:0] base;
        logic [42:0] first_cmd;
        int total;
        base  = $urandom & 32'hFFFF_FFFC;
        total = $urandom_range(40, 90);
        model_cmds(base, total);
        first_cmd = exp_cmd[0];
        snap();
        bus.stall = 1'b1;
        start_xfer(base, total);
        for (int i = 0; i < 5; i++) begin
            vectors++; if (bus.command !== 1'b1) begin fails++; $display("FAIL stall_command%0d got %b want 1", i, bus.command); end
            vectors++; if (bus.addr !== first_cmd[42:11]) begin fails++; $display("FAIL stall_addr%0d got %h want %h", i, bus.addr, first_cmd[42:11]); end
            vectors++; if (bus.burst_length !== first_cmd[10:0]) begin fails++; $display("FAIL stall_len%0d got %0d want %0d", i, bus.burst_length, first_cmd[10:0]); end
            @(posedge clock); #1;
        end
        drive_until_done(0, 100, 500, to);
        vectors++; if (to) begin fails++; $display("FAIL stall_timeout got no done want done"); end
        vectors++; if (cmd_log.size() - c0 !== exp_cmd.size()) begin fails++; $display("FAIL stall_cmd_count got %0d want %0d", cmd_log.size() - c0, exp_cmd.size()); end
        foreach (exp_cmd[i]) if (c0 + i < cmd_log.size()) begin
            vectors++; if (cmd_log[c0 + i] !== exp_cmd[i]) begin fails++; $display("FAIL stall_cmd%0d got %h want %h", i, cmd_log[c0 + i], exp_cmd[i]); end
        end
        vectors++; if (dout_log.size() - w0 !== total) begin fails++; $display("FAIL stall_words got %0d want %0d", dout_log.size() - w0, total); end
        for (int i = 0; i < total && w0 + i < dout_log.size(); i++) begin
            vectors++; if (dout_log[w0 + i] !== word_of(p0 + i)) begin fails++; $display("FAIL stall_word%0d got %h want %h", i, dout_log[w0 + i], word_of(p0 + i)); end
        end
        vectors++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL stall_done got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [31:0] base;
        int total;
        base  = $urandom & 32'hFFFF_FFFC;
        total = $urandom_range(64, 100);
        snap();
        bus.stall = 1'b0;
        bus.dout_ready = 1'b1;
        start_xfer(base, total);
        repeat (12) @(posedge clock);
        #1;
        for (int i = 0; i < 10; i++) begin
            bus.dout_ready = 1'b0;
            bus.start = (i == 3);
            @(negedge clock);
            vectors++; if (bus.dout_valid !== 1'b1) begin fails++; $display("FAIL bp_valid%0d got %b want 1", i, bus.dout_valid); end
            vectors++; if (bus.read !== 1'b0) begin fails++; $display("FAIL bp_read%0d got %b want 0", i, bus.read); end
            vectors++; if (bus.dout !== word_of(pop_cnt - 1)) begin fails++; $display("FAIL bp_hold%0d got %h want %h", i, bus.dout, word_of(pop_cnt - 1)); end
            @(posedge clock); #1;
        end
        bus.start = 1'b0;
        drive_until_done(20, 70, 2000, to);
        model_cmds(base, total);
        vectors++; if (to) begin fails++; $display("FAIL bp_timeout got no done want done"); end
        vectors++; if (cmd_log.size() - c0 !== exp_cmd.size()) begin fails++; $display("FAIL bp_cmd_count got %0d want %0d", cmd_log.size() - c0, exp_cmd.size()); end
        foreach (exp_cmd[i]) if (c0 + i < cmd_log.size()) begin
            vectors++; if (cmd_log[c0 + i] !== exp_cmd[i]) begin fails++; $display("FAIL bp_cmd%0d got %h want %h", i, cmd_log[c0 + i], exp_cmd[i]); end
        end
        vectors++; if (dout_log.size() - w0 !== total) begin fails++; $display("FAIL bp_words got %0d want %0d", dout_log.size() - w0, total); end
        for (int i = 0; i < total && w0 + i < dout_log.size(); i++) begin
            vectors++; if (dout_log[w0 + i] !== word_of(p0 + i)) begin fails++; $display("FAIL bp_word%0d got %h want %h", i, dout_log[w0 + i], word_of(p0 + i)); end
        end
        vectors++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL bp_done got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_wrap();
        bit to;
        logic [31:0] base = 32'hFFFF_FFC0;
        logic [31:0] end_addr;
        int total = 32;
        end_addr = base + 32'(total * BPW);
        snap();
        start_xfer(base, total);
        drive_until_done(0, 100, 500, to);
        model_cmds(base, total);
        vectors++; if (to) begin fails++; $display("FAIL wrap_timeout got no done want done"); end
        vectors++; if (cmd_log.size() - c0 !== exp_cmd.size()) begin fails++; $display("FAIL wrap_cmd_count got %0d want %0d", cmd_log.size() - c0, exp_cmd.size()); end
        foreach (exp_cmd[i]) if (c0 + i < cmd_log.size()) begin
            vectors++; if (cmd_log[c0 + i] !== exp_cmd[i]) begin fails++; $display("FAIL wrap_cmd%0d got %h want %h", i, cmd_log[c0 + i], exp_cmd[i]); end
        end
        vectors++; if (bus.addr !== end_addr) begin fails++; $display("FAIL wrap_end_addr got %h want %h", bus.addr, end_addr); end
        vectors++; if (dout_log.size() - w0 !== total) begin fails++; $display("FAIL wrap_words got %0d want %0d", dout_log.size() - w0, total); end
        for (int i = 0; i < total && w0 + i < dout_log.size(); i++) begin
            vectors++; if (dout_log[w0 + i] !== word_of(p0 + i)) begin fails++; $display("FAIL wrap_word%0d got %h want %h", i, dout_log[w0 + i], word_of(p0 + i)); end
        end
        vectors++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL wrap_done got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [31:0] base;
        int total;
        int dr;
        snap();
        start_xfer($urandom & 32'hFFFF_FFFC, $urandom_range(90, 150));
        for (int n = 0; n < 300 && cmd_log.size() < c0 + 2; n++) begin
            bus.stall = ($urandom_range(99) < 20);
            @(posedge clock); #1;
        end
        vectors++; if (cmd_log.size() < c0 + 2) begin fails++; $display("FAIL rmid_two_cmds got %0d want 2", cmd_log.size() - c0); end
        reset = 1'b0;
        bus.stall = 1'b0;
        @(posedge clock); #1;
        vectors++; if ({bus.busy, bus.done, bus.command, bus.read, bus.dout_valid} !== 5'b0) begin fails++; $display("FAIL rmid_flags got %b want 00000", {bus.busy, bus.done, bus.command, bus.read, bus.dout_valid}); end
        vectors++; if (bus.addr !== 32'h0) begin fails++; $display("FAIL rmid_addr got %h want 0", bus.addr); end
        vectors++; if (bus.burst_length !== 11'h0) begin fails++; $display("FAIL rmid_len got %0d want 0", bus.burst_length); end
        vectors++; if (bus.dout !== 32'h0) begin fails++; $display("FAIL rmid_dout got %h want 0", bus.dout); end
        reset = 1'b1;
        dr = done_cnt;
        repeat (5) @(posedge clock);
        #1;
        vectors++; if (done_cnt !== dr) begin fails++; $display("FAIL rmid_no_done got %0d want %0d", done_cnt, dr); end
        vectors++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rmid_idle_busy got %b want 0", bus.busy); end
        base  = $urandom & 32'hFFFF_FFFC;
        total = $urandom_range(1, 80);
        snap();
        start_xfer(base, total);
        drive_until_done(10, 80, 2000, to);
        model_cmds(base, total);
        vectors++; if (to) begin fails++; $display("FAIL rmid_timeout got no done want done"); end
        vectors++; if (cmd_log.size() - c0 !== exp_cmd.size()) begin fails++; $display("FAIL rmid_cmd_count got %0d want %0d", cmd_log.size() - c0, exp_cmd.size()); end
        foreach (exp_cmd[i]) if (c0 + i < cmd_log.size()) begin
            vectors++; if (cmd_log[c0 + i] !== exp_cmd[i]) begin fails++; $display("FAIL rmid_cmd%0d got %h want %h", i, cmd_log[c0 + i], exp_cmd[i]); end
        end
        vectors++; if (dout_log.size() - w0 !== total) begin fails++; $display("FAIL rmid_words got %0d want %0d", dout_log.size() - w0, total); end
        for (int i = 0; i < total && w0 + i < dout_log.size(); i++) begin
            vectors++; if (dout_log[w0 + i] !== word_of(p0 + i)) begin fails++; $display("FAIL rmid_word%0d got %h want %h", i, dout_log[w0 + i], word_of(p0 + i)); end
        end
        vectors++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL rmid_done got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_random();
        bit to;
        logic [31:0] base;
        int total;
        for (int k = 0; k < 6; k++) begin
            base  = $urandom & 32'hFFFF_FFFC;
            total = $urandom_range(0, 130);
            snap();
            start_xfer(base, total);
            drive_until_done(30, 60, 3000, to);
            model_cmds(base, total);
            vectors++; if (to) begin fails++; $display("FAIL rand%0d_timeout got no done want done", k); end
            vectors++; if (cmd_log.size() - c0 !== exp_cmd.size()) begin fails++; $display("FAIL rand%0d_cmd_count got %0d want %0d", k, cmd_log.size() - c0, exp_cmd.size()); end
            foreach (exp_cmd[i]) if (c0 + i < cmd_log.size()) begin
                vectors++; if (cmd_log[c0 + i] !== exp_cmd[i]) begin fails++; $display("FAIL rand%0d_cmd%0d got %h want %h", k, i, cmd_log[c0 + i], exp_cmd[i]); end
            end
            vectors++; if (dout_log.size() - w0 !== total) begin fails++; $display("FAIL rand%0d_words got %0d want %0d", k, dout_log.size() - w0, total); end
            for (int i = 0; i < total && w0 + i < dout_log.size(); i++) begin
                vectors++; if (dout_log[w0 + i] !== word_of(p0 + i)) begin fails++; $display("FAIL rand%0d_word%0d got %h want %h", k, i, dout_log[w0 + i], word_of(p0 + i)); end
            end
            vectors++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL rand%0d_done got %0d want 1", k, done_cnt - d0); end
        end
    endtask

    initial begin
        reset           = 1'b0;
        bus.start       = 1'b0;
        bus.base_addr   = '0;
        bus.total_words = '0;
        bus.stall       = 1'b0;
        bus.dout_ready  = 1'b1;
        test_reset();
        test_basic_70();
        test_zero();
        test_stall();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
